// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller: combinational load-use detection, a mul/div
// occupancy FSM that holds HI/LO readers and back-to-back mul/div, and a stall counter.
module pipe_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  input  logic        id_md_start,
  input  logic        id_md_div,
  input  logic        id_use_hilo,
  input  logic        id_branch_taken,
  output logic        stall,
  output logic        bubble,
  output logic        flush_ifid,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        lu, mdh, stall_int;

  always_comb begin
    lu = ex_m2reg & ex_wreg & (ex_rn != 5'd0) &
         ((id_use_rs & (id_rs == ex_rn)) | (id_use_rt & (id_rt == ex_rn)));
    mdh       = (state_q == BUSY) & (id_use_hilo | id_md_start);
    stall_int = lu | mdh;
  end

  // Outputs are gated by reset so a pipeline held in reset never sees a hold or flush.
  always_comb begin
    stall      = clrn & stall_int;
    bubble     = clrn & stall_int;
    flush_ifid = clrn & id_branch_taken & ~stall_int;
  end

  // A mul/div waiting in ID issues only from IDLE, so the BUSY->IDLE cycle never issues.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (id_md_start && !stall_int) begin
        state_d = BUSY;
        cnt_d   = id_md_div ? DIV_LOAD : MUL_LOAD;
      end
      BUSY: if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
            else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_int && stall_count_q != 32'hFFFF_FFFF) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= IDLE;
      cnt_q         <= 6'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign md_busy     = (state_q == BUSY);
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: load-use, mul/div occupancy, branch flush,
// mid-operation reset, counter saturation and the single-cycle mul corner.
module tb_pipe_stall_ctrl;
  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  id_rs, id_rt, ex_rn;
  logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg;
  logic        id_md_start, id_md_div, id_use_hilo, id_branch_taken;
  logic        stall, bubble, flush_ifid, md_busy;
  logic [31:0] stall_count;
  logic        stall1, bubble1, flush1, md_busy1;
  logic [31:0] stall_count1;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_wreg(ex_wreg),
    .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .id_md_start(id_md_start),
    .id_md_div(id_md_div), .id_use_hilo(id_use_hilo),
    .id_branch_taken(id_branch_taken), .stall(stall), .bubble(bubble),
    .flush_ifid(flush_ifid), .md_busy(md_busy), .stall_count(stall_count));

  pipe_stall_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(2)) dut1 (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_wreg(ex_wreg),
    .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .id_md_start(id_md_start),
    .id_md_div(id_md_div), .id_use_hilo(id_use_hilo),
    .id_branch_taken(id_branch_taken), .stall(stall1), .bubble(bubble1),
    .flush_ifid(flush1), .md_busy(md_busy1), .stall_count(stall_count1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_rs = 0; id_rt = 0; ex_rn = 0;
    id_use_rs = 0; id_use_rt = 0; ex_wreg = 0; ex_m2reg = 0;
    id_md_start = 0; id_md_div = 0; id_use_hilo = 0; id_branch_taken = 0;
  endtask

  task automatic set_lu();
    ex_m2reg = 1; ex_wreg = 1; ex_rn = 5; id_rs = 5; id_use_rs = 1;
  endtask

  initial begin
    clr_inputs();
    clrn = 0;
    // reset: hazard and branch present but outputs forced low
    set_lu(); id_branch_taken = 1;
    tick();
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_bubble", {31'd0, bubble}, 0);
    chk("rst_flush", {31'd0, flush_ifid}, 0);
    chk("rst_busy", {31'd0, md_busy}, 0);
    chk("rst_count", stall_count, 0);
    clr_inputs();
    clrn = 1;
    tick();

    // load-use: one stall cycle
    set_lu(); #1;
    chk("lu_stall", {31'd0, stall}, 1);
    chk("lu_bubble", {31'd0, bubble}, 1);
    tick();
    clr_inputs(); #1;
    chk("lu_release", {31'd0, stall}, 0);
    chk("lu_count", stall_count, 1);
    set_lu(); ex_rn = 0; id_rs = 0; #1;
    chk("lu_r0", {31'd0, stall}, 0);
    set_lu(); id_use_rs = 0; #1;
    chk("lu_nouse", {31'd0, stall}, 0);
    set_lu(); ex_wreg = 0; #1;
    chk("lu_nowreg", {31'd0, stall}, 0);
    set_lu(); id_rs = 0; id_rt = 5; id_use_rt = 1; #1;
    chk("lu_rt", {31'd0, stall}, 1);
    clr_inputs(); #1;

    // mul then mfhi
    id_md_start = 1; #1;
    chk("mul_issue_nostall", {31'd0, stall}, 0);
    tick();
    id_md_start = 0; id_use_hilo = 1; #1;
    n = 0;
    while (stall && md_busy && n < 10) begin n++; tick(); end
    chk("mul_stall_cycles", n, 4);
    chk("mul_busy_done", {31'd0, md_busy}, 0);
    chk("mul_count", stall_count, 5);
    clr_inputs(); #1;

    // back-to-back div
    id_md_start = 1; id_md_div = 1;
    tick();
    #1;
    n = 0;
    while (stall && n < 40) begin n++; tick(); end
    chk("div2_stall_cycles", n, 32);
    chk("div2_idle_gap", {31'd0, md_busy}, 0);
    tick();
    id_md_start = 0; id_md_div = 0; #1;
    n = 0;
    while (md_busy && n < 40) begin n++; tick(); end
    chk("div2_busy_cycles", n, 32);
    chk("div2_count", stall_count, 37);

    // branch with load-use
    set_lu(); id_branch_taken = 1; #1;
    chk("br_flush_stalled", {31'd0, flush_ifid}, 0);
    tick();
    clr_inputs(); id_branch_taken = 1; #1;
    chk("br_flush_next", {31'd0, flush_ifid}, 1);
    tick();
    clr_inputs(); #1;
    chk("br_count", stall_count, 38);

    // reset mid-div (cnt counts 31 down to 10)
    id_md_start = 1; id_md_div = 1;
    tick();
    id_md_start = 0; id_md_div = 0;
    repeat (21) tick();
    id_use_hilo = 1; #1;
    chk("mid_stall_pre", {31'd0, stall}, 1);
    clrn = 0; #1;
    chk("mid_busy", {31'd0, md_busy}, 0);
    chk("mid_stall", {31'd0, stall}, 0);
    chk("mid_count", stall_count, 0);
    tick();
    clrn = 1; #1;
    chk("post_rst_mfhi", {31'd0, stall}, 0);
    tick();
    chk("post_rst_count", stall_count, 0);
    clr_inputs(); #1;

    // saturation
    force dut.stall_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_count_q;
    #1;
    chk("sat_preload", stall_count, 32'hFFFF_FFFD);
    set_lu();
    tick(); chk("sat_fe", stall_count, 32'hFFFF_FFFE);
    tick(); chk("sat_ff", stall_count, 32'hFFFF_FFFF);
    tick(); chk("sat_hold1", stall_count, 32'hFFFF_FFFF);
    tick(); chk("sat_hold2", stall_count, 32'hFFFF_FFFF);
    clr_inputs();

    // MUL_CYCLES=1: one busy cycle, mfhi stalls once
    clrn = 0; #1; clrn = 1;
    tick();
    id_md_start = 1;
    tick();
    id_md_start = 0; id_use_hilo = 1; #1;
    chk("m1_busy", {31'd0, md_busy1}, 1);
    chk("m1_stall", {31'd0, stall1}, 1);
    tick();
    chk("m1_idle", {31'd0, md_busy1}, 0);
    chk("m1_release", {31'd0, stall1}, 0);
    chk("m1_count", stall_count1, 1);
    clr_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
